// File: rtl/axi_lite_sub_mem.sv
// AXI4-Lite subordinate backed by a small word-addressed register memory.
// The write path (AW/W/B) and the read path (AR/R) run as two independent FSMs.
// new_data gives one-cycle pulses, delayed by one cycle, for each handshake:
// [4]=AW [3]=W [2]=B [1]=AR [0]=R.
// Optional feature: define AXI_SUB_SLVERR_EN to reject accesses whose address
// bits above the memory range are nonzero (SLVERR). When it is undefined, the
// address wraps modulo MEM_DEPTH words.
module axi_lite_sub_mem #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int MEM_DEPTH = 16
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RVALID,
  input  logic                RREADY,
  output logic [4:0]          new_data
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  // Write path state
  w_state_e              w_state_q, w_state_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [ADDR_W-1:0]     awaddr_q, awaddr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;

  // Read path state
  r_state_e              r_state_q, r_state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  logic [4:0]            new_data_q;
  logic [DATA_W-1:0]     mem_q [MEM_DEPTH];

  // Handshakes and the effective write operands (captured copy or live bus)
  logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                  commit, mem_we, wr_err, rd_err;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic [STRB_W-1:0]     wr_strb;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic [MEM_DEPTH-1:0]  word_we;

  assign aw_hs = AWVALID & awready_q;
  assign w_hs  = WVALID & wready_q;
  assign b_hs  = bvalid_q & BREADY;
  assign ar_hs = ARVALID & arready_q;
  assign r_hs  = rvalid_q & RREADY;

  assign wr_addr = aw_held_q ? awaddr_q : AWADDR;
  assign wr_data = w_held_q ? wdata_q : WDATA;
  assign wr_strb = w_held_q ? wstrb_q : WSTRB;
  assign wr_idx  = wr_addr[LSB +: IDX_W];
  assign rd_idx  = ARADDR[LSB +: IDX_W];

`ifdef AXI_SUB_SLVERR_EN
  assign wr_err = |wr_addr[ADDR_W-1:LSB+IDX_W];
  assign rd_err = |ARADDR[ADDR_W-1:LSB+IDX_W];
`else
  assign wr_err = 1'b0;
  assign rd_err = 1'b0;
`endif

  // Sub-word and wrapped-away address bits are intentionally ignored
  logic unused_addr_bits;
  assign unused_addr_bits = ^{wr_addr, ARADDR};

  // The write commits on the edge where both address and data are available
  assign commit = (w_state_q == W_IDLE) & (aw_held_q | aw_hs) & (w_held_q | w_hs);
  assign mem_we = commit & ~wr_err;

  generate
    for (genvar gi = 0; gi < MEM_DEPTH; gi++) begin : g_word_we
      assign word_we[gi] = mem_we && (wr_idx == IDX_W'(gi));
    end
  endgenerate

  // Write FSM next-state: capture AW/W in any order, commit, then hold B until accepted
  always_comb begin
    w_state_d = w_state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        if (commit) begin
          w_state_d = W_RESP;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = wr_err ? RESP_SLVERR : RESP_OKAY;
        end else begin
          if (aw_hs) begin
            aw_held_d = 1'b1;
            awaddr_d  = AWADDR;
          end
          if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = WDATA;
            wstrb_d  = WSTRB;
          end
          awready_d = ~(aw_held_q | aw_hs);
          wready_d  = ~(w_held_q | w_hs);
        end
      end
      W_RESP: begin
        awready_d = 1'b0;
        wready_d  = 1'b0;
        if (b_hs) begin
          bvalid_d  = 1'b0;
          w_state_d = W_IDLE;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read FSM next-state: one-cycle read latency, response held until accepted
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rdata_d   = rd_err ? '0 : mem_q[rd_idx];
          rresp_d   = rd_err ? RESP_SLVERR : RESP_OKAY;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (r_hs) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Write path registers
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Read path registers and handshake pulse vector
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state_q  <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= 2'b00;
      new_data_q <= 5'b0;
    end else begin
      r_state_q  <= r_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      new_data_q <= {aw_hs, w_hs, b_hs, ar_hs, r_hs};
    end
  end

  // Memory words with byte enables; reads above sample the pre-write contents
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int w = 0; w < MEM_DEPTH; w++) mem_q[w] <= '0;
    end else begin
      for (int w = 0; w < MEM_DEPTH; w++) begin
        if (word_we[w]) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (wr_strb[b]) mem_q[w][8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end
    end
  end

  assign AWREADY  = awready_q;
  assign WREADY   = wready_q;
  assign BVALID   = bvalid_q;
  assign BRESP    = bresp_q;
  assign ARREADY  = arready_q;
  assign RVALID   = rvalid_q;
  assign RDATA    = rdata_q;
  assign RRESP    = rresp_q;
  assign new_data = new_data_q;

endmodule

// File: tb/tb_axi_lite_sub_mem.sv
// Directed testbench for axi_lite_sub_mem (DATA_W=64, MEM_DEPTH=16).
// Expected values follow AXI_SUB_SLVERR_EN when it is defined.
module tb_axi_lite_sub_mem;

  logic        ACLK;
  logic        ARESETn;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [63:0] WDATA;
  logic [7:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [63:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic [4:0]  new_data;

  int n_checks = 0;
  int n_fail   = 0;

  axi_lite_sub_mem #(.ADDR_W(32), .DATA_W(64), .MEM_DEPTH(16)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .new_data(new_data)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Global watchdog so the run can never hang
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic axi_write(input string tag, input logic [31:0] addr, input logic [63:0] data,
                           input logic [7:0] strb, input logic [1:0] exp_resp);
    logic aw_pend, w_pend, aw_fire, w_fire, got;
    logic [1:0] resp;
    resp = 2'b11; got = 1'b0;
    AWADDR = addr; WDATA = data; WSTRB = strb;
    AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
    aw_pend = 1'b1; w_pend = 1'b1;
    for (int c = 0; c < 20 && (aw_pend || w_pend); c++) begin
      aw_fire = AWVALID && AWREADY;
      w_fire  = WVALID && WREADY;
      tick();
      if (aw_fire) begin AWVALID = 1'b0; aw_pend = 1'b0; end
      if (w_fire)  begin WVALID = 1'b0;  w_pend = 1'b0;  end
    end
    AWVALID = 1'b0; WVALID = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (BVALID) begin resp = BRESP; got = 1'b1; end
      tick();
    end
    BREADY = 1'b0;
    check({tag, "_bdone"}, {63'b0, got}, 64'd1);
    check({tag, "_bresp"}, {62'b0, resp}, {62'b0, exp_resp});
    $display("write %s addr=%h data=%h strb=%h bresp=%b", tag, addr, data, strb, resp);
  endtask

  task automatic axi_read(input string tag, input logic [31:0] addr,
                          input logic [63:0] exp_data, input logic [1:0] exp_resp);
    logic fired, got;
    logic [63:0] data;
    logic [1:0]  resp;
    fired = 1'b0; got = 1'b0; data = '0; resp = 2'b11;
    ARADDR = addr; ARVALID = 1'b1; RREADY = 1'b1;
    for (int c = 0; c < 20 && !fired; c++) begin
      fired = ARREADY;
      tick();
    end
    ARVALID = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (RVALID) begin data = RDATA; resp = RRESP; got = 1'b1; end
      tick();
    end
    RREADY = 1'b0;
    check({tag, "_rdone"}, {63'b0, got}, 64'd1);
    check({tag, "_rdata"}, data, exp_data);
    check({tag, "_rresp"}, {62'b0, resp}, {62'b0, exp_resp});
    $display("read  %s addr=%h rdata=%h rresp=%b", tag, addr, data, resp);
  endtask

  logic [63:0] exp_w0;
  logic [1:0]  exp_err;
  logic [63:0] exp_wrap;

  initial begin
    ARESETn = 1'b0;
    AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_ctrl", {59'b0, AWREADY, WREADY, BVALID, ARREADY, RVALID}, 64'd0);
    check("rst_resp", {60'b0, BRESP, RRESP}, 64'd0);
    check("rst_rdata", RDATA, 64'd0);
    check("rst_new_data", {59'b0, new_data}, 64'd0);
    ARESETn = 1'b1;
    check("rdy_before_edge", {61'b0, AWREADY, WREADY, ARREADY}, 64'd0);
    tick();
    check("rdy_after_edge", {61'b0, AWREADY, WREADY, ARREADY}, 64'd7);
    $display("reset released");

    // Test 1: simultaneous AW/W write, then read, with pulse sequence
    AWADDR = 32'h08; WDATA = 64'hDEADBEEF_CAFEF00D; WSTRB = 8'hFF;
    AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    check("t1_bvalid", {61'b0, BVALID, BRESP}, {61'b0, 1'b1, 2'b00});
    check("t1_rdy_low", {62'b0, AWREADY, WREADY}, 64'd0);
    check("t1_nd_aw_w", {59'b0, new_data}, 64'b11000);
    tick();
    check("t1_b_done", {63'b0, BVALID}, 64'd0);
    check("t1_nd_b", {59'b0, new_data}, 64'b00100);
    check("t1_rdy_back", {62'b0, AWREADY, WREADY}, 64'd3);
    BREADY = 1'b0;
    ARADDR = 32'h08; ARVALID = 1'b1; RREADY = 1'b1;
    tick();
    ARVALID = 1'b0;
    check("t1_rvalid", {63'b0, RVALID}, 64'd1);
    check("t1_rdata", RDATA, 64'hDEADBEEF_CAFEF00D);
    check("t1_rresp", {62'b0, RRESP}, 64'd0);
    check("t1_nd_ar", {59'b0, new_data}, 64'b00010);
    check("t1_arready_low", {63'b0, ARREADY}, 64'd0);
    tick();
    check("t1_r_done", {63'b0, RVALID}, 64'd0);
    check("t1_nd_r", {59'b0, new_data}, 64'b00001);
    RREADY = 1'b0;
    $display("write/read t1 addr=08 done");

    // Test 2: W three cycles ahead of AW
    WDATA = 64'h11223344_55667788; WSTRB = 8'hFF; WVALID = 1'b1;
    tick();
    WVALID = 1'b0;
    check("t2_wready_low", {63'b0, WREADY}, 64'd0);
    check("t2_nd_w", {59'b0, new_data}, 64'b01000);
    tick(); tick();
    check("t2_no_commit", {62'b0, BVALID, AWREADY}, 64'b01);
    AWADDR = 32'h10; AWVALID = 1'b1; BREADY = 1'b1;
    tick();
    AWVALID = 1'b0;
    check("t2_commit", {63'b0, BVALID}, 64'd1);
    check("t2_nd_aw", {59'b0, new_data}, 64'b10000);
    tick();
    BREADY = 1'b0;
    check("t2_b_done", {63'b0, BVALID}, 64'd0);
    $display("write t2 addr=10 early W done");
    axi_read("t2_rd", 32'h10, 64'h11223344_55667788, 2'b00);
    axi_write("t2_strb", 32'h20, 64'hFFFFFFFF_FFFFFFFF, 8'h0F, 2'b00);
    axi_read("t2_strb_rd", 32'h20, 64'h00000000_FFFFFFFF, 2'b00);
    axi_write("t2_strb0", 32'h20, 64'h12345678_12345678, 8'h00, 2'b00);
    axi_read("t2_strb0_rd", 32'h20, 64'h00000000_FFFFFFFF, 2'b00);

    // Test 3: B and R back-pressure
    AWADDR = 32'h28; WDATA = 64'h0BAD_F00D_0000_0042; WSTRB = 8'hFF;
    AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t3_b_stall", {59'b0, BVALID, BRESP, AWREADY, WREADY}, 64'b10000);
      tick();
    end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    check("t3_b_release", {59'b0, new_data}, 64'b00100);
    check("t3_b_gone", {63'b0, BVALID}, 64'd0);
    $display("write t3 addr=28 after B stall");
    ARADDR = 32'h28; ARVALID = 1'b1; RREADY = 1'b0;
    tick();
    ARVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t3_r_stall_ctl", {61'b0, RVALID, RRESP == 2'b00, ARREADY}, 64'b110);
      check("t3_r_stall_data", RDATA, 64'h0BAD_F00D_0000_0042);
      tick();
    end
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    check("t3_r_release", {59'b0, new_data}, 64'b00001);
    check("t3_r_gone", {62'b0, RVALID, ARREADY}, 64'b01);
    $display("read  t3 addr=28 after R stall");

    // Test 4: same-edge write commit and read of one word
    axi_write("t4_init", 32'h18, 64'h1, 8'hFF, 2'b00);
    AWADDR = 32'h18; WDATA = 64'h2; WSTRB = 8'hFF; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
    ARADDR = 32'h18; ARVALID = 1'b1; RREADY = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    check("t4_both_valid", {62'b0, BVALID, RVALID}, 64'b11);
    check("t4_old_data", RDATA, 64'h1);
    tick();
    BREADY = 1'b0; RREADY = 1'b0;
    $display("collision t4 addr=18 done");
    axi_read("t4_new", 32'h18, 64'h2, 2'b00);

    // Test 5: reset while B and R are pending
    AWADDR = 32'h30; WDATA = 64'h55; WSTRB = 8'hFF; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
    ARADDR = 32'h08; ARVALID = 1'b1; RREADY = 1'b0;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    check("t5_pending", {62'b0, BVALID, RVALID}, 64'b11);
    #2;
    ARESETn = 1'b0;
    #1;
    check("t5_async_clr", {59'b0, AWREADY, WREADY, BVALID, ARREADY, RVALID}, 64'd0);
    check("t5_rdata_clr", RDATA, 64'd0);
    BREADY = 1'b1; RREADY = 1'b1;
    tick(); tick();
    ARESETn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_no_resp", {62'b0, BVALID, RVALID}, 64'd0);
    end
    BREADY = 1'b0; RREADY = 1'b0;
    $display("reset t5 mid-transaction done");
    axi_read("t5_rd30", 32'h30, 64'd0, 2'b00);
    axi_read("t5_rd08", 32'h08, 64'd0, 2'b00);

    // Test 6: out-of-range addresses, unaligned and top-word accesses
`ifdef AXI_SUB_SLVERR_EN
    exp_w0 = 64'd0; exp_err = 2'b10; exp_wrap = 64'd0;
`else
    exp_w0 = 64'hA5A5A5A5_5A5A5A5A; exp_err = 2'b00; exp_wrap = 64'h77;
`endif
    axi_write("t6_w0", 32'h00, 64'hA5A5A5A5_5A5A5A5A, 8'hFF, 2'b00);
    axi_read("t6_oor_rd", 32'h80, exp_w0, exp_err);
    axi_write("t6_oor_wr", 32'h88, 64'h77, 8'hFF, exp_err);
    axi_read("t6_unaligned", 32'h0C, exp_wrap, 2'b00);
    axi_write("t6_top", 32'h78, 64'hF00D, 8'hFF, 2'b00);
    axi_read("t6_top_rd", 32'h7F, 64'hF00D, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
